// File: rtl/pc_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The fetch stage drives req/addr; the memory answers with ready/rdata in the same cycle.
interface pc_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_stage.sv
// Program counter and multicycle instruction-fetch sequencer for the MIPS core.
// Fetches at pc, presents instr/pc to decode, commits npc on retire, halts on error.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          TIMEOUT  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             npc,
    input  logic                    stall,
    pc_fetch_stage_if.master        imem,
    output logic [31:0]             pc,
    output logic [31:0]             instr,
    output logic                    instr_valid,
    output logic                    err,
    output logic [1:0]              err_code,
    output logic [31:0]             fetch_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_VALID,
        S_ERR
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            err_code_q    <= 2'b00;
            fetch_count_q <= 32'h0;
            wait_cnt_q    <= 8'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            err_code_q    <= err_code_d;
            fetch_count_q <= fetch_count_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        err_code_d    = err_code_q;
        fetch_count_d = fetch_count_q;
        wait_cnt_d    = wait_cnt_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (imem.imem_ready) begin
                    instr_d       = imem.imem_rdata;
                    fetch_count_d = fetch_count_q + 32'd1;
                    state_d       = S_VALID;
                end else begin
                    wait_cnt_d = 8'd1;
                    state_d    = S_WAIT;
                end
            end
            // A ready on the last allowed wait cycle still wins over the timeout.
            S_WAIT: begin
                if (imem.imem_ready) begin
                    instr_d       = imem.imem_rdata;
                    fetch_count_d = fetch_count_q + 32'd1;
                    wait_cnt_d    = 8'd0;
                    state_d       = S_VALID;
                end else if (wait_cnt_q == TIMEOUT_CNT) begin
                    err_code_d = 2'b10;
                    state_d    = S_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_VALID: begin
                if (!stall) begin
                    if (npc[1:0] != 2'b00) begin
                        err_code_d = 2'b01;
                        state_d    = S_ERR;
                    end else begin
                        pc_d    = npc;
                        state_d = S_FETCH;
                    end
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    // Address is the pc register itself, so it cannot move while a request is pending.
    always_comb begin
        imem.imem_req  = (state_q == S_FETCH) || (state_q == S_WAIT);
        imem.imem_addr = pc_q;
        instr_valid    = (state_q == S_VALID);
        err            = (state_q == S_ERR);
        pc             = pc_q;
        instr          = instr_q;
        err_code       = err_code_q;
        fetch_count    = fetch_count_q;
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed scenarios plus randomized
// fetch latencies and branch targets checked against a transaction-level model.
module tb_pc_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          TIMEOUT  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] npc;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        err;
    logic [1:0]  err_code;
    logic [31:0] fetch_count;

    pc_fetch_stage_if imem_bus ();

    pc_fetch_stage #(
        .RESET_PC(RESET_PC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .npc        (npc),
        .stall      (stall),
        .imem       (imem_bus),
        .pc         (pc),
        .instr      (instr),
        .instr_valid(instr_valid),
        .err        (err),
        .err_code   (err_code),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_pc;
    logic [31:0] model_count;
    logic [31:0] model_instr;

    localparam logic [132:0] RESET_VECTOR =
        {RESET_PC, 32'h0, 1'b0, 1'b0, RESET_PC, 1'b0, 2'b00, 32'h0};

    // Inputs change and outputs are sampled on the falling edge, mid-cycle.
    task automatic tick;
        @(negedge clk);
    endtask

    task automatic start_from_reset;
        rst = 1'b1;
        stall = 1'b0;
        npc = 32'h0;
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        model_pc = RESET_PC;
        model_count = 32'h0;
        model_instr = 32'h0;
    endtask

    // Precondition: DUT is presenting a fetch request. Memory answers after lat wait cycles.
    task automatic fetch_with_latency(input int lat, input logic [31:0] data);
        for (int k = 0; k <= lat; k++) begin
            checks++;
            if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== model_pc) begin
                errors++;
                $display("[TB] FAIL fetch_hold k=%0d: req=%b addr=%h, expected req=1 addr=%h",
                         k, imem_bus.imem_req, imem_bus.imem_addr, model_pc);
            end
            imem_bus.imem_ready = (k == lat);
            imem_bus.imem_rdata = (k == lat) ? data : $urandom();
            tick();
        end
        imem_bus.imem_ready = 1'($urandom_range(0, 1));
        imem_bus.imem_rdata = $urandom();
        model_count = model_count + 32'd1;
        model_instr = data;
        checks++;
        if (instr_valid !== 1'b1 || instr !== model_instr || fetch_count !== model_count
            || pc !== model_pc || imem_bus.imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fetch_capture: valid=%b instr=%h count=%0d pc=%h req=%b, expected valid=1 instr=%h count=%0d pc=%h req=0",
                     instr_valid, instr, fetch_count, pc, imem_bus.imem_req,
                     model_instr, model_count, model_pc);
        end
    endtask

    task automatic commit(input logic [31:0] target);
        stall = 1'b0;
        npc = target;
        tick();
        model_pc = target;
        checks++;
        if (pc !== model_pc || instr_valid !== 1'b0 || imem_bus.imem_req !== 1'b1
            || imem_bus.imem_addr !== model_pc || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL commit: pc=%h valid=%b req=%b addr=%h err=%b, expected pc=%h valid=0 req=1 addr=%h err=0",
                     pc, instr_valid, imem_bus.imem_req, imem_bus.imem_addr, err, model_pc, model_pc);
        end
    endtask

    task automatic stall_cycle(input logic [31:0] npc_value);
        stall = 1'b1;
        npc = npc_value;
        imem_bus.imem_ready = 1'($urandom_range(0, 1));
        imem_bus.imem_rdata = $urandom();
        tick();
        checks++;
        if (instr_valid !== 1'b1 || pc !== model_pc || instr !== model_instr
            || err !== 1'b0 || fetch_count !== model_count) begin
            errors++;
            $display("[TB] FAIL stall_hold: valid=%b pc=%h instr=%h err=%b count=%0d, expected valid=1 pc=%h instr=%h err=0 count=%0d",
                     instr_valid, pc, instr, err, fetch_count, model_pc, model_instr, model_count);
        end
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({pc, instr, instr_valid, imem_bus.imem_req, imem_bus.imem_addr, err, err_code, fetch_count}
            !== RESET_VECTOR) begin
            errors++;
            $display("[TB] FAIL reset_values: pc=%h instr=%h valid=%b req=%b addr=%h err=%b code=%b count=%h",
                     pc, instr, instr_valid, imem_bus.imem_req, imem_bus.imem_addr, err, err_code, fetch_count);
        end
    endtask

    task automatic test_first_fetch;
        start_from_reset();
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = 32'h2408_0005;
        checks++;
        if (imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_no_req: req=%b valid=%b, expected 0 0", imem_bus.imem_req, instr_valid);
        end
        tick();
        checks++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0000_3000) begin
            errors++;
            $display("[TB] FAIL first_req: req=%b addr=%h, expected 1 00003000", imem_bus.imem_req, imem_bus.imem_addr);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h2408_0005 || fetch_count !== 32'd1) begin
            errors++;
            $display("[TB] FAIL first_valid: valid=%b instr=%h count=%0d, expected 1 24080005 1",
                     instr_valid, instr, fetch_count);
        end
    endtask

    task automatic test_sequential;
        start_from_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            fetch_with_latency(0, $urandom());
            checks++;
            if (pc !== RESET_PC + 32'(4 * i)) begin
                errors++;
                $display("[TB] FAIL seq_pc i=%0d: pc=%h, expected %h", i, pc, RESET_PC + 32'(4 * i));
            end
            if (i < 3) commit(model_pc + 32'd4);
        end
        checks++;
        if (fetch_count !== 32'd4) begin
            errors++;
            $display("[TB] FAIL seq_count: count=%0d, expected 4", fetch_count);
        end
    endtask

    task automatic test_random_traffic;
        logic [31:0] target;
        start_from_reset();
        tick();
        for (int i = 0; i < 12; i++) begin
            fetch_with_latency((i == 3) ? TIMEOUT : int'($urandom_range(0, 5)), $urandom());
            for (int s = 0; s < int'($urandom_range(0, 2)); s++) stall_cycle($urandom());
            target = $urandom();
            target[1:0] = 2'b00;
            if (i == 6) target = 32'hFFFF_FFFC;
            if (i < 11) commit(target);
        end
    endtask

    task automatic test_stall;
        start_from_reset();
        tick();
        fetch_with_latency(1, $urandom());
        for (int i = 0; i < 5; i++) stall_cycle((i % 2 == 0) ? 32'h0000_3040 : 32'h0000_3002);
        commit(32'h0000_3040);
        checks++;
        if (pc !== 32'h0000_3040) begin
            errors++;
            $display("[TB] FAIL stall_release_pc: pc=%h, expected 00003040", pc);
        end
    endtask

    task automatic test_timeout;
        start_from_reset();
        tick();
        for (int k = 0; k <= TIMEOUT; k++) begin
            checks++;
            if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== RESET_PC || err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL timeout_wait k=%0d: req=%b addr=%h err=%b, expected 1 %h 0",
                         k, imem_bus.imem_req, imem_bus.imem_addr, err, RESET_PC);
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (err !== 1'b1 || err_code !== 2'b10 || imem_bus.imem_req !== 1'b0
                || instr_valid !== 1'b0 || pc !== RESET_PC || fetch_count !== 32'd0) begin
                errors++;
                $display("[TB] FAIL timeout_err k=%0d: err=%b code=%b req=%b valid=%b pc=%h count=%0d, expected 1 10 0 0 %h 0",
                         k, err, err_code, imem_bus.imem_req, instr_valid, pc, fetch_count, RESET_PC);
            end
            imem_bus.imem_ready = 1'b1;
            tick();
        end
    endtask

    task automatic test_misaligned_and_async_reset;
        start_from_reset();
        tick();
        fetch_with_latency(0, $urandom());
        commit(32'h0000_3040);
        fetch_with_latency(2, $urandom());
        stall = 1'b0;
        npc = 32'h0000_3006;
        tick();
        checks++;
        if (err !== 1'b1 || err_code !== 2'b01 || pc !== 32'h0000_3040
            || imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL misaligned: err=%b code=%b pc=%h req=%b valid=%b, expected 1 01 00003040 0 0",
                     err, err_code, pc, imem_bus.imem_req, instr_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({pc, instr, instr_valid, imem_bus.imem_req, imem_bus.imem_addr, err, err_code, fetch_count}
            !== RESET_VECTOR) begin
            errors++;
            $display("[TB] FAIL err_async_reset: pc=%h instr=%h valid=%b req=%b addr=%h err=%b code=%b count=%h",
                     pc, instr, instr_valid, imem_bus.imem_req, imem_bus.imem_addr, err, err_code, fetch_count);
        end
    endtask

    task automatic test_reset_mid_wait;
        start_from_reset();
        tick();
        fetch_with_latency(0, $urandom());
        commit(32'h0000_3100);
        imem_bus.imem_ready = 1'b0;
        tick();
        checks++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0000_3100) begin
            errors++;
            $display("[TB] FAIL wait_before_reset: req=%b addr=%h, expected 1 00003100",
                     imem_bus.imem_req, imem_bus.imem_addr);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (imem_bus.imem_req !== 1'b0 || imem_bus.imem_addr !== RESET_PC || pc !== RESET_PC
            || fetch_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL wait_async_reset: req=%b addr=%h pc=%h count=%0d, expected 0 %h %h 0",
                     imem_bus.imem_req, imem_bus.imem_addr, pc, fetch_count, RESET_PC, RESET_PC);
        end
    endtask

    initial begin
        rst = 1'b0;
        stall = 1'b0;
        npc = 32'h0;
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        test_reset();
        test_first_fetch();
        test_sequential();
        test_random_traffic();
        test_stall();
        test_timeout();
        test_misaligned_and_async_reset();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
